// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze player engine: direction encodings,
// FSM state enum and index-width helpers.
package maze_pkg;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam int unsigned COORD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/maze_sprite_window.sv
// Sprite window compare and sprite ROM address generation from the displayed
// cell position and the current pixel coordinates (purely combinational).
module maze_sprite_window
    import maze_pkg::*;
#(
    parameter int unsigned CELL_PX = 20,
    parameter int unsigned SPR_W   = 18,
    parameter int unsigned SPR_H   = 18,
    parameter int unsigned ROW_W   = 5,
    parameter int unsigned COL_W   = 5,
    parameter int unsigned SPR_AW  = 9
) (
    input  logic [ROW_W-1:0]  drow_i,
    input  logic [COL_W-1:0]  dcol_i,
    input  logic [9:0]        h_cnt_i,
    input  logic [9:0]        v_cnt_i,
    output logic              sprite_on_o,
    output logic [SPR_AW-1:0] sprite_addr_o
);

    localparam logic [COORD_W-1:0] CELL  = COORD_W'(CELL_PX);
    localparam logic [COORD_W-1:0] X_OFF = COORD_W'((CELL_PX - SPR_W) / 2);
    localparam logic [COORD_W-1:0] Y_OFF = COORD_W'((CELL_PX - SPR_H) / 2);
    localparam logic [COORD_W-1:0] SW    = COORD_W'(SPR_W);
    localparam logic [COORD_W-1:0] SH    = COORD_W'(SPR_H);

    logic [COORD_W-1:0] h, v, x0, y0, dx, dy;
    logic               in_x, in_y;

    always_comb begin
        h    = COORD_W'(h_cnt_i);
        v    = COORD_W'(v_cnt_i);
        x0   = COORD_W'(dcol_i) * CELL + X_OFF;
        y0   = COORD_W'(drow_i) * CELL + Y_OFF;
        dx   = h - x0;
        dy   = v - y0;
        in_x = (h >= x0) && (h < x0 + SW);
        in_y = (v >= y0) && (v < y0 + SH);
        sprite_on_o   = in_x && in_y;
        // Address is only meaningful inside the window; outside it is forced to 0.
        sprite_addr_o = sprite_on_o
                      ? (SPR_AW'(dx) + SPR_AW'(dy) * SPR_AW'(SPR_W))
                      : '0;
    end

endmodule

// File: rtl/maze_player_ctrl.sv
// Player movement engine: validates one-hot move requests against the wall
// memory, commits legal moves, counts them and flags arrival at the goal.
//  state   | meaning
//  IDLE    | waiting for a one-hot move request
//  RD      | wall read issued, waiting for wall data
//  CHK     | wall data valid: bump or commit
//  DONE    | goal reached, moves ignored until restart
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned COLS      = 32,
    parameter int unsigned ROWS      = 24,
    parameter int unsigned CELL_PX   = 20,
    parameter int unsigned SPR_W     = 18,
    parameter int unsigned SPR_H     = 18,
    parameter int unsigned START_ROW = 1,
    parameter int unsigned START_COL = 1,
    parameter int unsigned GOAL_ROW  = 22,
    parameter int unsigned GOAL_COL  = 30,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned ROW_W    = idx_w(ROWS),
    localparam int unsigned COL_W    = idx_w(COLS),
    localparam int unsigned ADDR_W   = idx_w(ROWS * COLS),
    localparam int unsigned SPR_AW   = idx_w(SPR_W * SPR_H)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              restart_i,
    input  logic [3:0]        move_req_i,
    output logic              wall_rd_o,
    output logic [ADDR_W-1:0] wall_addr_o,
    input  logic              wall_data_i,
    input  logic              vblank_i,
    input  logic [9:0]        h_cnt_i,
    input  logic [9:0]        v_cnt_i,
    output logic [ROW_W-1:0]  row_pos_o,
    output logic [COL_W-1:0]  col_pos_o,
    output logic              sprite_on_o,
    output logic [SPR_AW-1:0] sprite_addr_o,
    output logic              busy_o,
    output logic              bump_o,
    output logic              goal_pulse_o,
    output logic              at_goal_o,
    output logic [CNT_W-1:0]  move_cnt_o
);

    localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0] COL_START = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_GOAL  = ROW_W'(GOAL_ROW);
    localparam logic [COL_W-1:0] COL_GOAL  = COL_W'(GOAL_COL);

    state_e            state_q;
    logic [ROW_W-1:0]  row_q, tgt_row_q, drow_q;
    logic [COL_W-1:0]  col_q, tgt_col_q, dcol_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] wall_addr_q;
    logic              wall_rd_q, busy_q, bump_q, goal_pulse_q, at_goal_q;

    logic [ROW_W-1:0]  tgt_row_d;
    logic [COL_W-1:0]  tgt_col_d;
    logic [ADDR_W-1:0] tgt_idx_d;
    logic              off_edge_d;

    always_comb begin
        tgt_row_d  = row_q;
        tgt_col_d  = col_q;
        off_edge_d = 1'b0;
        case (move_req_i)
            DIR_UP:    if (row_q == '0)      off_edge_d = 1'b1;
                       else                  tgt_row_d  = row_q - ROW_W'(1);
            DIR_DOWN:  if (row_q == ROW_LAST) off_edge_d = 1'b1;
                       else                  tgt_row_d  = row_q + ROW_W'(1);
            DIR_LEFT:  if (col_q == '0)      off_edge_d = 1'b1;
                       else                  tgt_col_d  = col_q - COL_W'(1);
            DIR_RIGHT: if (col_q == COL_LAST) off_edge_d = 1'b1;
                       else                  tgt_col_d  = col_q + COL_W'(1);
            default:   ;
        endcase
        tgt_idx_d = ADDR_W'(tgt_row_d) * ADDR_W'(COLS) + ADDR_W'(tgt_col_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            row_q        <= ROW_START;
            col_q        <= COL_START;
            tgt_row_q    <= ROW_START;
            tgt_col_q    <= COL_START;
            drow_q       <= ROW_START;
            dcol_q       <= COL_START;
            cnt_q        <= '0;
            wall_addr_q  <= '0;
            wall_rd_q    <= 1'b0;
            busy_q       <= 1'b0;
            bump_q       <= 1'b0;
            goal_pulse_q <= 1'b0;
            at_goal_q    <= 1'b0;
        end else begin
            wall_rd_q    <= 1'b0;
            bump_q       <= 1'b0;
            goal_pulse_q <= 1'b0;
            // Restart overrides any in-flight check; its pending wall data is discarded.
            if (restart_i) begin
                state_q   <= ST_IDLE;
                row_q     <= ROW_START;
                col_q     <= COL_START;
                cnt_q     <= '0;
                at_goal_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (one_hot4(move_req_i) && !at_goal_q) begin
                            if (off_edge_d) begin
                                bump_q <= 1'b1;
                            end else begin
                                wall_rd_q   <= 1'b1;
                                wall_addr_q <= tgt_idx_d;
                                tgt_row_q   <= tgt_row_d;
                                tgt_col_q   <= tgt_col_d;
                                busy_q      <= 1'b1;
                                state_q     <= ST_RD;
                            end
                        end
                    end
                    ST_RD: state_q <= ST_CHK;
                    ST_CHK: begin
                        busy_q <= 1'b0;
                        if (wall_data_i) begin
                            bump_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            row_q <= tgt_row_q;
                            col_q <= tgt_col_q;
                            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                            if (tgt_row_q == ROW_GOAL && tgt_col_q == COL_GOAL) begin
                                at_goal_q    <= 1'b1;
                                goal_pulse_q <= 1'b1;
                                state_q      <= ST_DONE;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
            // Display copy only tracks the committed position during vertical blank.
            if (vblank_i) begin
                drow_q <= row_q;
                dcol_q <= col_q;
            end
        end
    end

    maze_sprite_window #(
        .CELL_PX (CELL_PX),
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .ROW_W   (ROW_W),
        .COL_W   (COL_W),
        .SPR_AW  (SPR_AW)
    ) u_sprite (
        .drow_i        (drow_q),
        .dcol_i        (dcol_q),
        .h_cnt_i       (h_cnt_i),
        .v_cnt_i       (v_cnt_i),
        .sprite_on_o   (sprite_on_o),
        .sprite_addr_o (sprite_addr_o)
    );

    assign wall_rd_o    = wall_rd_q;
    assign wall_addr_o  = wall_addr_q;
    assign row_pos_o    = row_q;
    assign col_pos_o    = col_q;
    assign busy_o       = busy_q;
    assign bump_o       = bump_q;
    assign goal_pulse_o = goal_pulse_q;
    assign at_goal_o    = at_goal_q;
    assign move_cnt_o   = cnt_q;

endmodule
